// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide engine feeding the HI/LO registers.
// Multiply is signed radix-2 Booth; divide is restoring division on magnitudes
// followed by sign correction. Both take WIDTH iterations, one per clock.
// Optional feature macro MDU_UNSIGNED_EN adds the Unsgn port (multu/divu).
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             RESET_in,
  input  logic             MultOp,
  input  logic             DivOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MDU_UNSIGNED_EN
  input  logic             Unsgn,
`endif
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Div0,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH:0]   acc_q;      // mul: {hi, lo, q-1}; div: {0, rem, quotient}
  logic [WIDTH-1:0]   m_q;        // multiplicand or divisor magnitude
  logic               op_div_q, sgn_q, neg_quo_q, neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               div0_q, busy_q, done_q;
  logic               busy_d, done_d;

  logic               start_mul_s, start_div_s, div_zero_s, start_s, last_s;
  logic               in_signed_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     hi_ext_s, m_ext_s, sum_s, shifted_s, diff_s;
  logic               ge_s;
  logic [WIDTH-1:0]   trial_s;
  logic [2*WIDTH:0]   acc_it_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;

  function automatic logic [WIDTH-1:0] neg_fn(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

`ifdef MDU_UNSIGNED_EN
  assign in_signed_s = ~Unsgn;
`else
  assign in_signed_s = 1'b1;
`endif

  assign start_mul_s = (state_q == S_IDLE) && MultOp;
  assign start_div_s = (state_q == S_IDLE) && !MultOp && DivOp && (B != {WIDTH{1'b0}});
  assign div_zero_s  = (state_q == S_IDLE) && !MultOp && DivOp && (B == {WIDTH{1'b0}});
  assign start_s     = start_mul_s || start_div_s;
  assign last_s      = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

  assign a_neg_s = in_signed_s & A[WIDTH-1];
  assign b_neg_s = in_signed_s & B[WIDTH-1];
  assign a_mag_s = a_neg_s ? neg_fn(A) : A;
  assign b_mag_s = b_neg_s ? neg_fn(B) : B;

  // State register.
  always_ff @(posedge clock) begin
    if (!RESET_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE; divide-by-zero stays in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_s ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_s ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_RUN:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // One iteration of Booth multiply or restoring divide on the accumulator.
  always_comb begin
    hi_ext_s = {sgn_q & acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    m_ext_s  = {sgn_q & m_q[WIDTH-1], m_q};
    sum_s    = hi_ext_s;
    if (sgn_q) begin
      case (acc_q[1:0])
        2'b01:   sum_s = hi_ext_s + m_ext_s;
        2'b10:   sum_s = hi_ext_s - m_ext_s;
        default: sum_s = hi_ext_s;
      endcase
    end else if (acc_q[1]) begin
      sum_s = hi_ext_s + m_ext_s;
    end else begin
      sum_s = hi_ext_s;
    end
    // Remainder is always below the divisor, so a negative diff means "too big".
    shifted_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, m_q};
    ge_s      = ~diff_s[WIDTH];
    trial_s   = ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
    if (op_div_q) begin
      acc_it_s = {1'b0, trial_s, acc_q[WIDTH-2:0], ge_s};
    end else begin
      acc_it_s = {sum_s, acc_q[WIDTH:1]};
    end
  end

  // Final HI/LO values, with sign correction for divide.
  always_comb begin
    if (op_div_q) begin
      res_lo_s = neg_quo_q ? neg_fn(acc_it_s[WIDTH-1:0]) : acc_it_s[WIDTH-1:0];
      res_hi_s = neg_rem_q ? neg_fn(acc_it_s[2*WIDTH-1:WIDTH]) : acc_it_s[2*WIDTH-1:WIDTH];
    end else begin
      res_lo_s = acc_it_s[WIDTH:1];
      res_hi_s = acc_it_s[2*WIDTH:WIDTH+1];
    end
  end

  // Datapath registers: operand latch, iteration, HI/LO load and sticky Div0.
  always_ff @(posedge clock) begin
    if (!RESET_in) begin
      acc_q     <= {(2*WIDTH+1){1'b0}};
      m_q       <= {WIDTH{1'b0}};
      op_div_q  <= 1'b0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (start_mul_s) begin
        acc_q    <= {{WIDTH{1'b0}}, B, 1'b0};
        m_q      <= A;
        op_div_q <= 1'b0;
        sgn_q    <= in_signed_s;
      end else if (start_div_s) begin
        acc_q     <= {{(WIDTH+1){1'b0}}, a_mag_s};
        m_q       <= b_mag_s;
        op_div_q  <= 1'b1;
        sgn_q     <= in_signed_s;
        neg_quo_q <= a_neg_s ^ b_neg_s;
        neg_rem_q <= a_neg_s;
      end else if (state_q == S_RUN) begin
        acc_q <= acc_it_s;
      end
      if (start_s) begin
        cnt_q <= {CW{1'b0}};
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
      if (last_s) begin
        hi_q <= res_hi_s;
        lo_q <= res_lo_s;
      end
      if (start_s) begin
        div0_q <= 1'b0;
      end else if (div_zero_s) begin
        div0_q <= 1'b1;
      end
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Div0 = div0_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
